// File: rtl/caches_types_pkg.sv
// caches_types_pkg: shared cache/memory types and arbiter constants
package caches_types_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;
  localparam int ARB_STARVE_LIMIT = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache and dcache requests onto one RAM port, dcache first with an ifetch starvation guard
module mem_arbiter
  import caches_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);
  arb_state_t state, next_state;
  logic [3:0] starve_cnt, next_cnt;
  logic       starved, access;
  assign iload   = ramload;
  assign dload   = ramload;
  assign access  = ramstate == RAM_ACCESS;
  assign starved = iREN && (starve_cnt >= 4'(STARVE_LIMIT));
  // grant state, starve counter and sticky error flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      ram_err    <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
      if (state != ARB_IDLE && ramstate == RAM_ERROR) ram_err <= 1'b1;
    end
  end
  // grant decision and RAM port steering; outputs follow state so reset drops enables at once
  always_comb begin
    next_state = state;
    next_cnt   = starve_cnt;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    case (state)
      ARB_IDLE: begin
        next_cnt   = iREN ? starve_cnt : '0;
        next_state = starved ? ARB_I : (dREN || dWEN) ? ARB_D : iREN ? ARB_I : ARB_IDLE;
      end
      ARB_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (access) begin
          iwait      = 1'b0;
          next_state = ARB_IDLE;
          next_cnt   = '0;
        end else if (!iREN) next_state = ARB_IDLE;
      end
      ARB_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (access) begin
          dwait      = 1'b0;
          next_state = ARB_IDLE;
          next_cnt   = (iREN && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
        end else if (!dREN && !dWEN) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus multi-cycle sequences for mem_arbiter
module tb_mem_arbiter;
  import caches_types_pkg::*;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        irn;
    logic [31:0] ia;
    logic        drn, dwn;
    logic [31:0] da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_ra, e_rst;
  } vec_t;

  vec_t v[18];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int dn;
    bit seen;
    v[0]  = '{"imiss_c1",  1, 32'h40, 0, 0, 32'h0,   32'h0,        2'd0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[1]  = '{"imiss_c2",  1, 32'h40, 0, 0, 32'h0,   32'h0,        2'd1, 32'h0,        1, 1, 1, 0, 32'h40,  32'h0};
    v[2]  = '{"imiss_c3",  1, 32'h40, 0, 0, 32'h0,   32'h0,        2'd1, 32'h0,        1, 1, 1, 0, 32'h40,  32'h0};
    v[3]  = '{"imiss_c4",  1, 32'h40, 0, 0, 32'h0,   32'h0,        2'd2, 32'h24080001, 0, 1, 1, 0, 32'h40,  32'h0};
    v[4]  = '{"imiss_c5",  0, 32'h40, 0, 0, 32'h0,   32'h0,        2'd0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[5]  = '{"simul_c1",  1, 32'h80, 1, 0, 32'h100, 32'h0,        2'd2, 32'h11111111, 1, 1, 0, 0, 32'h0,   32'h0};
    v[6]  = '{"simul_c2",  1, 32'h80, 1, 0, 32'h100, 32'h0,        2'd2, 32'h11111111, 1, 0, 1, 0, 32'h100, 32'h0};
    v[7]  = '{"simul_c3",  1, 32'h80, 0, 0, 32'h100, 32'h0,        2'd2, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[8]  = '{"simul_c4",  1, 32'h80, 0, 0, 32'h100, 32'h0,        2'd2, 32'h22222222, 0, 1, 1, 0, 32'h80,  32'h0};
    v[9]  = '{"simul_c5",  0, 32'h80, 0, 0, 32'h0,   32'h0,        2'd0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[10] = '{"write_c1",  0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 2'd0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[11] = '{"write_c2",  0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 2'd1, 32'h0,        1, 1, 0, 1, 32'h200, 32'hDEADBEEF};
    v[12] = '{"write_c3",  0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 2'd2, 32'h33333333, 1, 0, 0, 1, 32'h200, 32'hDEADBEEF};
    v[13] = '{"write_c4",  0, 32'h0,  0, 0, 32'h0,   32'h0,        2'd0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[14] = '{"aband_c1",  0, 32'h0,  1, 0, 32'h300, 32'h0,        2'd1, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
    v[15] = '{"aband_c2",  0, 32'h0,  1, 0, 32'h300, 32'h0,        2'd1, 32'h0,        1, 1, 1, 0, 32'h300, 32'h0};
    v[16] = '{"aband_c3",  0, 32'h0,  0, 0, 32'h300, 32'h0,        2'd1, 32'h0,        1, 1, 0, 0, 32'h300, 32'h0};
    v[17] = '{"aband_c4",  0, 32'h0,  0, 0, 32'h0,   32'h0,        2'd2, 32'h44444444, 1, 1, 0, 0, 32'h0,   32'h0};

    #1;
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_ram_err", ram_err, 0);
    chk("rst_state", dut.state, ARB_IDLE);
    chk("rst_cnt", dut.starve_cnt, 0);
    next_cycle();
    nRST = 1'b1;

    for (int k = 0; k < 18; k++) begin
      iREN = v[k].irn; iaddr = v[k].ia; dREN = v[k].drn; dWEN = v[k].dwn;
      daddr = v[k].da; dstore = v[k].ds; ramstate = v[k].rs; ramload = v[k].rl;
      @(negedge CLK);
      chk({v[k].name, "_iwait"}, iwait, v[k].e_iw);
      chk({v[k].name, "_dwait"}, dwait, v[k].e_dw);
      chk({v[k].name, "_ramREN"}, ramREN, v[k].e_rr);
      chk({v[k].name, "_ramWEN"}, ramWEN, v[k].e_rw);
      chk({v[k].name, "_ramaddr"}, ramaddr, v[k].e_ra);
      chk({v[k].name, "_ramstore"}, ramstore, v[k].e_rst);
      chk({v[k].name, "_iload"}, iload, v[k].rl);
      chk({v[k].name, "_dload"}, dload, v[k].rl);
      chk({v[k].name, "_ram_err"}, ram_err, 0);
      next_cycle();
    end
    chk("after_table_state", dut.state, ARB_IDLE);

    iREN = 1; iaddr = 32'h44; dREN = 1; dWEN = 0; daddr = 32'h500; ramstate = RAM_ACCESS; ramload = 32'h55;
    dn = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      if (!dwait) dn++;
      if (!iwait) begin
        seen = 1;
        chk("starve_dcount", dn, 4);
        chk("starve_cnt_at_i", dut.starve_cnt, 4);
        chk("starve_iaddr", ramaddr, 32'h44);
      end
      next_cycle();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL starve_timeout got no icache grant exp grant within 40 cycles");
    end
    chk("starve_cnt_after", dut.starve_cnt, 0);
    chk("starve_state_after", dut.state, ARB_IDLE);
    iREN = 0; dREN = 0; ramstate = RAM_FREE;
    next_cycle();

    iREN = 1; iaddr = 32'h60;
    @(negedge CLK);
    chk("err_idle_iwait", iwait, 1);
    next_cycle();
    ramstate = RAM_ERROR;
    @(negedge CLK);
    chk("err_c1_ramREN", ramREN, 1);
    chk("err_c1_iwait", iwait, 1);
    next_cycle();
    chk("err_sticky_set", ram_err, 1);
    @(negedge CLK);
    chk("err_c2_iwait", iwait, 1);
    next_cycle();
    ramstate = RAM_ACCESS; ramload = 32'h66;
    @(negedge CLK);
    chk("err_access_iwait", iwait, 0);
    chk("err_access_iload", iload, 32'h66);
    chk("err_access_ram_err", ram_err, 1);
    next_cycle();
    iREN = 0; ramstate = RAM_FREE;
    @(negedge CLK);
    chk("err_sticky_hold", ram_err, 1);
    next_cycle();

    dWEN = 1; daddr = 32'h700; dstore = 32'h12345678; ramstate = RAM_BUSY;
    next_cycle();
    @(negedge CLK);
    chk("rstd_ramWEN_before", ramWEN, 1);
    #2;
    nRST = 0;
    #1;
    chk("rstd_ramWEN", ramWEN, 0);
    chk("rstd_ramREN", ramREN, 0);
    chk("rstd_ram_err", ram_err, 0);
    chk("rstd_iwait", iwait, 1);
    chk("rstd_dwait", dwait, 1);
    @(posedge CLK);
    @(negedge CLK);
    chk("rstd_hold_dwait", dwait, 1);
    chk("rstd_hold_ramWEN", ramWEN, 0);
    #1;
    nRST = 1; dWEN = 0;
    next_cycle();
    chk("rstd_state", dut.state, ARB_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and beside the data cache.
- Consumes the icache miss request (iREN/iaddr) and the dcache request (dREN/dWEN/daddr/dstore).
- Serialises both onto the single RAM port and returns iwait/iload and dwait/dload.
- Registered grant FSM with dcache priority and a bounded starvation guard for instruction fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- STARVE_LIMIT, 4, max consecutive dcache grants completed while iREN is pending before icache is forced next; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  reset, asynchronous, active-low.
- iREN  input  1  icache read request; held until iwait low.
- iaddr  input  ADDR_W  icache word address.
- iwait  output  1  0 only in the cycle icache data is valid.
- iload  output  DATA_W  icache read data.
- dREN  input  1  dcache read request.
- dWEN  input  1  dcache write request.
- daddr  input  ADDR_W  dcache address.
- dstore  input  DATA_W  dcache write data.
- dwait  output  1  0 only in the cycle the dcache transaction completes.
- dload  output  DATA_W  dcache read data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  DATA_W  RAM write data.
- ramload  input  DATA_W  RAM read data.
- ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ram_err  output  1  sticky flag, set on any ERROR seen while granted.

Behaviour:
- Reset (async, nRST low):
  - state ARB_IDLE, starve counter 0, ram_err 0.
  - iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iload and dload are combinational pass-throughs of ramload at all times; consumers sample only when their wait is 0.
- ARB_IDLE:
  - No RAM enables; both waits 1.
  - Next state, in priority order:
    1. If iREN=1 and starve counter >= STARVE_LIMIT: ARB_I.
    2. Else if dREN or dWEN: ARB_D.
    3. Else if iREN: ARB_I.
    4. Else stay.
- ARB_I:
  - ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - If ramstate==ACCESS: iwait=0 this cycle, next ARB_IDLE, starve counter cleared to 0.
  - If iREN drops without ACCESS: next ARB_IDLE, no completion signalled.
  - Else stay.
- ARB_D:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - If dREN and dWEN are both 1: write takes precedence; ramREN forced to 0.
  - If ramstate==ACCESS: dwait=0 this cycle, next ARB_IDLE. If iREN=1 that cycle, starve counter increments, saturating at 15.
  - If dREN and dWEN both drop without ACCESS: next ARB_IDLE.
  - Else stay.
- Starve counter clears whenever iREN=0 in ARB_IDLE.
- Exactly one transaction per grant; every grant returns to ARB_IDLE for one cycle, so there are no back-to-back grants.
- Minimum latency from request to wait low is 2 cycles: IDLE decision, then the grant cycle with ACCESS.
- BUSY and FREE while granted: hold the state and keep the enables asserted.
- ERROR while granted: set ram_err (sticky until reset), keep the enables asserted; the request is retried until ACCESS.
- Simultaneous iREN and dcache request in IDLE with the counter below the limit: dcache wins.
- Reset asserted mid-grant: enables drop immediately (asynchronously), no completion pulse.
- Never assert ramREN and ramWEN together; never assert either outside a grant state.

Decomposition:
- Add to caches_types_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_I, ARB_D}.
  - ramstate_t, if not already shared with the RAM model.
- Add STARVE_LIMIT default as a package constant.
- Single module, no sub-module. The starve counter is small enough to inline.

Test Plan:
- I-miss only: iREN=1, iaddr=0x0000_0040; RAM gives BUSY x2 then ACCESS with ramload=0x2408_0001 -> ramREN=1 and ramaddr=0x40 from cycle 2; iwait=0 with iload=0x2408_0001 in cycle 4; state IDLE in cycle 5.
- Simultaneous requests: iREN=1 (iaddr=0x80) and dREN=1 (daddr=0x100) in the same cycle, RAM ACCESS immediately -> dcache served first (dwait=0 in cycle 2); icache granted after the IDLE gap (iwait=0 in cycle 4).
- Starvation guard: dcache issues back-to-back requests with iREN held, STARVE_LIMIT=4 -> exactly 4 dcache completions, then icache granted even though dREN=1; counter reads 0 afterwards.
- Write priority: dREN=1, dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF; dwait=0 on ACCESS.
- Error and reset: ramstate=ERROR for 2 cycles during ARB_I, then ACCESS -> ram_err=1 and stays 1, iwait=0 on ACCESS. Then nRST pulsed during an ARB_D BUSY cycle -> ramWEN/ramREN=0 immediately, ram_err=0, waits=1, no dwait pulse.
- Abandoned request: dREN drops while in ARB_D with ramstate=BUSY -> next cycle ARB_IDLE, ram enables 0, dwait never 0.
